// File: rtl/pal_cfg_loader.sv
// PAL configuration sequencer: accepts bytes over valid/ready and shifts them
// LSB first into the PAL one-bit configuration chain, then holds a sticky done flag.
module pal_cfg_loader #(
    parameter int unsigned N        = 8,
    parameter int unsigned P        = 11,
    parameter int unsigned M        = 6,
    parameter int unsigned CFG_BITS = 2 * N * P + P * M,
    parameter int unsigned CNT_W    = $clog2(CFG_BITS + 1)
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             cfg_out,
    output logic             cfg_shift,
    output logic             cfg_done,
    output logic [CNT_W-1:0] bits_left
);

    localparam logic [CNT_W-1:0] BITS_INIT = CNT_W'(CFG_BITS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [7:0]       sreg;
    logic [7:0]       sreg_n;
    logic [3:0]       byte_cnt;
    logic [3:0]       byte_cnt_n;
    logic [CNT_W-1:0] bits_left_n;
    logic             done_n;

    // State and datapath registers
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state     <= IDLE;
            sreg      <= 8'h00;
            byte_cnt  <= 4'd0;
            bits_left <= BITS_INIT;
            cfg_done  <= 1'b0;
        end else begin
            state     <= state_n;
            sreg      <= sreg_n;
            byte_cnt  <= byte_cnt_n;
            bits_left <= bits_left_n;
            cfg_done  <= done_n;
        end
    end

    // Next-state and output decode; abort overrides everything, including a handshake
    always_comb begin
        state_n     = state;
        sreg_n      = sreg;
        byte_cnt_n  = byte_cnt;
        bits_left_n = bits_left;
        done_n      = cfg_done;
        in_ready    = 1'b0;
        cfg_shift   = 1'b0;
        cfg_out     = 1'b0;

        if (abort) begin
            state_n     = IDLE;
            sreg_n      = 8'h00;
            byte_cnt_n  = 4'd0;
            bits_left_n = BITS_INIT;
            done_n      = 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_n     = LOAD;
                        bits_left_n = BITS_INIT;
                        done_n      = 1'b0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        state_n = SHIFT;
                        sreg_n  = in_data;
                        // Final byte may be partial; only its low bits are shifted
                        byte_cnt_n = (32'(bits_left) >= 32'd8) ? 4'd8 : 4'(bits_left);
                    end
                end
                SHIFT: begin
                    sreg_n      = {1'b0, sreg[7:1]};
                    bits_left_n = bits_left - CNT_W'(1);
                    byte_cnt_n  = byte_cnt - 4'd1;
                    if (bits_left == CNT_W'(1)) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else if (byte_cnt == 4'd1) begin
                        state_n = LOAD;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        in_ready  = (state == LOAD);
        cfg_shift = (state == SHIFT);
        cfg_out   = (state == SHIFT) & sreg[0];
    end

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Self-checking bench for pal_cfg_loader: directed vector table plus randomized
// loads compared against a bit-stream model built from the byte list.
module tb_pal_cfg_loader;

    localparam int CFG_BITS = 242;
    localparam int NBYTES   = 31;
    localparam int CNT_W    = 8;

    logic             clk = 1'b0;
    logic             res_n;
    logic             start;
    logic             abort;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             cfg_out;
    logic             cfg_shift;
    logic             cfg_done;
    logic [CNT_W-1:0] bits_left;

    int n_pass = 0;
    int n_total = 0;

    pal_cfg_loader dut (
        .clk      (clk),
        .res_n    (res_n),
        .start    (start),
        .abort    (abort),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .cfg_out  (cfg_out),
        .cfg_shift(cfg_shift),
        .cfg_done (cfg_done),
        .bits_left(bits_left)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       ab;
        logic       v;
        logic [7:0] d;
        logic       rdy;
        logic       sh;
        logic       out;
        logic       dn;
        int         bl;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pack_out();
        return ({28'd0, in_ready, cfg_shift, cfg_out, cfg_done} << 16) | int'(bits_left);
    endfunction

    function automatic int pack_exp(input logic rdy, input logic sh, input logic out,
                                    input logic dn, input int bl);
        return ({28'd0, rdy, sh, out, dn} << 16) | bl;
    endfunction

    // One full (or aborted) load; mode 0=0xA5, 1=0xFF, 2=random bytes
    task automatic do_load(input int mode, input int max_gap, input int abort_at,
                           input bit do_start, input bit start_noise);
        logic [7:0] bytes [NBYTES];
        bit   got [$];
        int   bidx = 0, gap, cyc = 0, shifts = 0, ready_cyc = 0;
        int   bl_err = 0, out_err = 0, rdy_err = 0, bit_err = 0;
        bit   aborted = 0;
        for (int i = 0; i < NBYTES; i++)
            bytes[i] = (mode == 0) ? 8'hA5 : (mode == 1) ? 8'hFF : 8'($urandom);
        if (do_start) begin
            start = 1'b1;
            step();
            start = 1'b0;
        end
        gap = int'($urandom_range(max_gap, 0));
        while (!cfg_done && cyc < 3000) begin
            if (cfg_shift) begin
                got.push_back(cfg_out);
                if (int'(bits_left) != CFG_BITS - shifts) bl_err++;
                shifts++;
            end else if (cfg_out) out_err++;
            if (in_ready) ready_cyc++;
            if (in_ready == cfg_shift) rdy_err++;
            start    = start_noise ? 1'($urandom) : 1'b0;
            in_valid = 1'b0;
            if (in_ready && bidx < NBYTES) begin
                if (gap > 0) gap--;
                else begin
                    in_valid = 1'b1;
                    in_data  = bytes[bidx];
                    bidx++;
                    gap = int'($urandom_range(max_gap, 0));
                end
            end else if (max_gap == 0 && bidx < NBYTES) begin
                in_valid = 1'b1;
                in_data  = bytes[bidx];
            end
            if (abort_at >= 0 && cfg_shift && shifts == abort_at) begin
                abort = 1'b1;
                start = 1'b1;
                step();
                abort = 1'b0;
                start = 1'b0;
                in_valid = 1'b0;
                chk("abort_state", pack_out(), pack_exp(0, 0, 0, 0, CFG_BITS));
                aborted = 1;
                break;
            end
            step();
            cyc++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (!aborted) begin
            chk("load_timeout", int'(cfg_done), 1);
            chk("shift_count", shifts, CFG_BITS);
            for (int i = 0; i < got.size() && i < CFG_BITS; i++)
                if (got[i] != bytes[i / 8][i % 8]) bit_err++;
            chk("stream_bits", bit_err, 0);
            chk("bits_left_track", bl_err, 0);
            chk("out_when_idle", out_err, 0);
            chk("ready_vs_shift", rdy_err, 0);
            chk("bytes_used", bidx, NBYTES);
            chk("done_state", pack_out(), pack_exp(0, 0, 0, 1, 0));
            if (max_gap == 0) chk("load_cycles", ready_cyc, NBYTES);
        end
    endtask

    initial begin
        int busy;
        res_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        //            st ab v  d       rdy sh out dn bl
        vecs[0]  = '{1, 1, 0, 8'h00, 0, 0, 0, 0, 242};
        vecs[1]  = '{0, 0, 1, 8'hFF, 0, 0, 0, 0, 242};
        vecs[2]  = '{1, 0, 0, 8'h00, 1, 0, 0, 0, 242};
        vecs[3]  = '{1, 0, 0, 8'h00, 1, 0, 0, 0, 242};
        vecs[4]  = '{0, 0, 1, 8'h03, 0, 1, 1, 0, 242};
        vecs[5]  = '{1, 0, 1, 8'hFF, 0, 1, 1, 0, 241};
        vecs[6]  = '{0, 0, 0, 8'h00, 0, 1, 0, 0, 240};
        vecs[7]  = '{1, 1, 0, 8'h00, 0, 0, 0, 0, 242};
        vecs[8]  = '{1, 0, 0, 8'h00, 1, 0, 0, 0, 242};
        vecs[9]  = '{0, 1, 1, 8'h80, 0, 0, 0, 0, 242};
        vecs[10] = '{1, 0, 0, 8'h00, 1, 0, 0, 0, 242};
        vecs[11] = '{0, 0, 1, 8'h01, 0, 1, 1, 0, 242};
        vecs[12] = '{0, 0, 0, 8'h00, 0, 1, 0, 0, 241};

        repeat (2) @(posedge clk);
        @(negedge clk);
        res_n = 1'b1;
        step();
        chk("reset_state", pack_out(), pack_exp(0, 0, 0, 0, CFG_BITS));

        for (int i = 0; i < 13; i++) begin
            start    = vecs[i].st;
            abort    = vecs[i].ab;
            in_valid = vecs[i].v;
            in_data  = vecs[i].d;
            step();
            chk($sformatf("vec%0d", i), pack_out(),
                pack_exp(vecs[i].rdy, vecs[i].sh, vecs[i].out, vecs[i].dn, vecs[i].bl));
        end
        start    = 1'b0;
        in_valid = 1'b0;
        abort    = 1'b1;
        step();
        abort = 1'b0;

        do_load(0, 0, -1, 1, 0);
        step();
        step();
        chk("done_held", pack_out(), pack_exp(0, 0, 0, 1, 0));
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_from_done", pack_out(), pack_exp(1, 0, 0, 0, CFG_BITS));
        do_load(1, 0, -1, 0, 0);

        do_load(2, 5, -1, 1, 1);
        do_load(2, 0, 83, 1, 0);
        do_load(0, 2, -1, 1, 0);

        // Asynchronous reset mid-byte
        start = 1'b1;
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        step();
        in_valid = 1'b0;
        step();
        chk("pre_reset_shift", int'(cfg_shift), 1);
        #2 res_n = 1'b0;
        #1;
        chk("async_reset", pack_out(), pack_exp(0, 0, 0, 0, CFG_BITS));
        @(negedge clk);
        res_n    = 1'b1;
        in_valid = 1'b1;
        busy     = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (cfg_shift || in_ready || cfg_done) busy++;
        end
        in_valid = 1'b0;
        chk("idle_after_reset", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
